// File: rtl/lstm_feature_rx.sv
// Receive-side front end of the LSTM input path: requests one frame of features,
// packs INPUT_SIZE words into a vector and offers it to the core via valid/ready.
module lstm_feature_rx #(
    parameter int INPUT_SIZE = 26,
    parameter int TIME_STEP  = 148,
    parameter int D_WL       = 24,
    localparam int W_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
    localparam int T_W = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       w_x_en,
    input  logic                       f_in_valid,
    input  logic [D_WL-1:0]            feature_in,
    output logic [INPUT_SIZE*D_WL-1:0] x_vec,
    output logic                       x_valid,
    input  logic                       x_ready,
    output logic [T_W-1:0]             t_idx,
    output logic                       x_last,
    output logic                       done,
    output logic                       busy,
    output logic                       err_overrun
);

    localparam logic [W_W-1:0] W_LAST = W_W'(INPUT_SIZE - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(TIME_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_HOLD
    } state_t;

    state_t          state_reg;
    logic [W_W-1:0]  w_cnt_reg;
    logic [T_W-1:0]  t_idx_reg;
    logic            w_x_en_reg;
    logic            x_valid_reg;
    logic            x_last_reg;
    logic            done_reg;
    logic            busy_reg;
    logic            err_overrun_reg;
    logic [D_WL-1:0] word_reg [INPUT_SIZE];
    logic            word_wr;

    assign word_wr = (state_reg == S_RECV) && f_in_valid;

    // Control FSM; every output is registered so the core sees glitch-free strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            w_cnt_reg       <= '0;
            t_idx_reg       <= '0;
            w_x_en_reg      <= 1'b0;
            x_valid_reg     <= 1'b0;
            x_last_reg      <= 1'b0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            w_x_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            if (f_in_valid && (state_reg != S_RECV)) begin
                err_overrun_reg <= 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        t_idx_reg       <= '0;
                        err_overrun_reg <= f_in_valid;
                        w_x_en_reg      <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= S_REQ;
                    end
                end
                S_REQ: begin
                    w_cnt_reg <= '0;
                    state_reg <= S_RECV;
                end
                S_RECV: begin
                    if (f_in_valid) begin
                        if (w_cnt_reg == W_LAST) begin
                            x_valid_reg <= 1'b1;
                            x_last_reg  <= (t_idx_reg == T_LAST);
                            state_reg   <= S_HOLD;
                        end else begin
                            w_cnt_reg <= w_cnt_reg + W_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (x_ready) begin
                        x_valid_reg <= 1'b0;
                        x_last_reg  <= 1'b0;
                        if (t_idx_reg == T_LAST) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            t_idx_reg  <= t_idx_reg + T_W'(1);
                            w_x_en_reg <= 1'b1;
                            state_reg  <= S_REQ;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Frame storage: each word is overwritten in place, never cleared between frames.
    generate
        for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg[gi] <= '0;
                end else if (word_wr && (w_cnt_reg == W_W'(gi))) begin
                    word_reg[gi] <= feature_in;
                end
            end
            assign x_vec[gi*D_WL +: D_WL] = word_reg[gi];
        end
    endgenerate

    assign w_x_en      = w_x_en_reg;
    assign x_valid     = x_valid_reg;
    assign x_last      = x_last_reg;
    assign t_idx       = t_idx_reg;
    assign done        = done_reg;
    assign busy        = busy_reg;
    assign err_overrun = err_overrun_reg;

endmodule
